mac_sequencer: RTL

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_sequencer_pkg.sv | 26 ++
 rtl/mac_sequencer_beat_pipe.sv | 29 ++
 rtl/mac_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/mac_sequencer_pkg.sv
// Shared DSP-slice definitions for the MAC sequencer.
// Opmode encodings and the per-beat tag that follows each beat to the slice output.
package mac_sequencer_pkg;

    localparam logic [7:0] OPM_ZERO  = 8'h00;
    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;
    localparam logic [7:0] OPM_HOLD  = 8'h08;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    // A bubble keeps P untouched so idle slots never disturb a partial sum.
    function automatic logic [7:0] beatOpmode(input beat_t beat);
        if (!beat.valid) begin
            return OPM_HOLD;
        end
        return beat.first ? OPM_FIRST : OPM_ACC;
    endfunction

endpackage

// File: rtl/mac_sequencer_beat_pipe.sv
// Fixed-depth delay line that re-times beat tags to the DSP slice P/carryout update.
module beat_pipe #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mac_sequencer.sv
// Feeds an external DSP slice one tap per beat and collects each NTAPS-long dot product.
// Results are held until accepted; the last tap of the next product stalls if one is still pending.
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int NTAPS = 8,
    parameter int LAT   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [17:0] s_a,
    input  logic [17:0] s_b,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [7:0]  dsp_opmode,
    input  logic [47:0] dsp_p,
    input  logic        dsp_carryout,
    output logic        r_valid,
    input  logic        r_ready,
    output logic [47:0] r_data,
    output logic        r_ovf
);

    localparam int CNT_W = $clog2(NTAPS);

    logic [CNT_W-1:0] tapCnt_q;
    logic [CNT_W-1:0] tapCnt_d;
    logic [17:0]      dspA_q;
    logic [17:0]      dspB_q;
    logic [7:0]       opmode_q;
    beat_t            beatDly_q;
    logic             ovf_q;
    logic             rValid_q;
    logic [47:0]      rData_q;
    logic             rOvf_q;

    logic             isFirst;
    logic             isLast;
    logic             accept;
    beat_t            beatIn;
    logic [BEAT_W-1:0] pipeOutBits;
    beat_t            pipeOut;
    logic             capture;
    logic             ovfNow;

    assign isFirst = (tapCnt_q == '0);
    assign isLast  = (tapCnt_q == CNT_W'(NTAPS - 1));
    assign s_ready = !rst && !(isLast && rValid_q && !r_ready);
    assign accept  = s_valid && s_ready;

    always_comb begin
        beatIn       = '0;
        beatIn.valid = accept;
        beatIn.first = accept && isFirst;
        beatIn.last  = accept && isLast;
        tapCnt_d     = tapCnt_q;
        if (accept) begin
            tapCnt_d = isLast ? '0 : tapCnt_q + CNT_W'(1);
        end
    end

    beat_pipe #(
        .WIDTH (BEAT_W),
        .DEPTH (LAT)
    ) u_beat_pipe (
        .clk (clk),
        .rst (rst),
        .d_i (beatIn),
        .q_o (pipeOutBits)
    );

    // pipeOut lines up with the slice P/carryout produced by that beat.
    assign pipeOut = beat_t'(pipeOutBits);
    assign capture = pipeOut.valid && pipeOut.last;
    assign ovfNow  = pipeOut.first ? dsp_carryout : (ovf_q | dsp_carryout);

    always_ff @(posedge clk) begin
        if (rst) begin
            tapCnt_q  <= '0;
            dspA_q    <= '0;
            dspB_q    <= '0;
            opmode_q  <= OPM_ZERO;
            beatDly_q <= '0;
            ovf_q     <= 1'b0;
            rValid_q  <= 1'b0;
            rData_q   <= '0;
            rOvf_q    <= 1'b0;
        end else begin
            tapCnt_q  <= tapCnt_d;
            dspA_q    <= accept ? s_a : '0;
            dspB_q    <= accept ? s_b : '0;
            beatDly_q <= beatIn;
            opmode_q  <= beatOpmode(beatDly_q);
            if (pipeOut.valid) begin
                ovf_q <= ovfNow;
            end
            // A fresh capture takes priority over the handshake clearing r_valid.
            if (capture) begin
                rData_q  <= dsp_p;
                rOvf_q   <= ovfNow;
                rValid_q <= 1'b1;
            end else if (rValid_q && r_ready) begin
                rValid_q <= 1'b0;
            end
        end
    end

    assign dsp_a      = dspA_q;
    assign dsp_b      = dspB_q;
    assign dsp_opmode = opmode_q;
    assign r_valid    = rValid_q;
    assign r_data     = rData_q;
    assign r_ovf      = rOvf_q;

endmodule
